// File: rtl/ram_port_pkg.sv
// ram_port_pkg: shared widths and FSM states for ram_port_master.
// The CLEAR state exists only when RAM_PORT_MASTER_CLEAR_EN is defined.
package ram_port_pkg;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 9;
`ifdef RAM_PORT_MASTER_CLEAR_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
`endif
endpackage

// File: rtl/ram_port_master_if.sv
// ram_port_master_if: command, write-data, read-data and RAM pin bundle.
interface ram_port_master_if #(parameter int DW = 16, parameter int AW = 9) ();
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid, rdata_ready, rdata_last;
  logic [DW-1:0] rdata;
  logic          ram_cen, ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready, ram_dout,
    output cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, ram_cen, ram_wen, ram_addr, ram_din
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready, ram_dout,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, ram_cen, ram_wen, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_port_rfifo.sv
// ram_port_rfifo: 2-entry read-data FIFO; simultaneous push and pop keep count and order.
module ram_port_rfifo #(parameter int W = 17) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= !wp;
      end
      if (pop) rp <= !rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  assign valid = count != 2'd0;
  assign dout = mem[rp];
endmodule

// File: rtl/ram_port_master.sv
// ram_port_master: burst command to single-port synchronous RAM master with 2-deep read buffer.
// Define RAM_PORT_MASTER_CLEAR_EN to zero the whole RAM after reset before accepting commands.
module ram_port_master
  import ram_port_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  ram_port_master_if.master      bus,
  output logic                   busy
);
  state_t state, nxt;
  logic [AW-1:0] addr, len, cnt;
  logic infl, infl_last, issue, beat, step, last, fvalid, pop;
  logic [1:0] count;
  logic [DW:0] head;
  assign last = cnt == len;
  assign pop = fvalid && bus.rdata_ready;
  always_ff @(posedge clk or posedge rst)
`ifdef RAM_PORT_MASTER_CLEAR_EN
    if (rst) state <= CLEAR;
`else
    if (rst) state <= IDLE;
`endif
    else state <= nxt;
  always_comb begin
    nxt = state;
    bus.cmd_ready = 1'b0;
    bus.wdata_ready = 1'b0;
    bus.ram_cen = 1'b1;
    bus.ram_wen = 1'b1;
    bus.ram_din = '0;
    beat = 1'b0;
    issue = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) nxt = bus.cmd_write ? WRITE : READ;
      end
      WRITE: begin
        bus.wdata_ready = 1'b1;
        beat = bus.wdata_valid;
        step = beat;
        bus.ram_cen = !beat;
        bus.ram_wen = !beat;
        bus.ram_din = beat ? bus.wdata : '0;
        if (beat && last) nxt = IDLE;
      end
      READ: begin
        // credit counts buffered beats plus the one whose data arrives next cycle
        issue = ({1'b0, count} + {2'b0, infl}) < 3'd2;
        step = issue;
        bus.ram_cen = !issue;
        if (issue && last) nxt = DRAIN;
      end
      DRAIN: if (count == 2'd0 && !infl) nxt = IDLE;
`ifdef RAM_PORT_MASTER_CLEAR_EN
      CLEAR: begin
        step = 1'b1;
        bus.ram_cen = 1'b0;
        bus.ram_wen = 1'b0;
        if (&addr) nxt = IDLE;
      end
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      len <= '0;
      cnt <= '0;
      infl <= 1'b0;
      infl_last <= 1'b0;
    end else begin
      if (state == IDLE && bus.cmd_valid) begin
        addr <= bus.cmd_addr;
        len <= bus.cmd_len;
        cnt <= '0;
      end else if (step) begin
        addr <= addr + 1'b1;
        cnt <= cnt + 1'b1;
      end
      infl <= issue;
      infl_last <= issue && last;
    end
  ram_port_rfifo #(.W(DW + 1)) u_rfifo (
    .clk(clk),
    .rst(rst),
    .push(infl),
    .pop(pop),
    .din({infl_last, bus.ram_dout}),
    .valid(fvalid),
    .dout(head),
    .count(count)
  );
  assign bus.rdata_valid = fvalid;
  assign bus.rdata = head[DW-1:0];
  assign bus.rdata_last = fvalid && head[DW];
  assign bus.ram_addr = addr;
  assign busy = state != IDLE;
endmodule
